// File: rtl/hacd_pkg.sv
// Shared AXI write-path types and helpers for the hawk write arbiter.
package hacd_pkg;

    // Requester -> master write request: one AW and one W beat per transaction.
    typedef struct packed {
        logic [39:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        awvalid;
        logic        wvalid;
    } axi_wr_reqpkt_t;

    typedef struct packed {
        logic awready;
        logic wready;
    } axi_wr_rdypkt_t;

    typedef struct packed {
        logic [1:0] bresp;
        logic       bvalid;
    } axi_wr_resppkt_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_WAIT_B} wrarb_state_t;

    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Index width for n entries; never narrower than one bit.
    function automatic int clogb2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hawk_rr_picker.sv
// Round-robin picker: first pending index at or above ptr_i, wrapping modulo N.
module hawk_rr_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  pend_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        int j;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!vld_o && pend_i[j]) begin
                vld_o = 1'b1;
                idx_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/hawk_axiwr_arb.sv
// Round-robin arbiter sharing one AXI write master port among NUM_REQ requesters.
// One transaction in flight; the grant is held from AW/W until the B response.
// Optional B-response watchdog enabled by HAWK_WRARB_TIMEOUT_EN.
module hawk_axiwr_arb
    import hacd_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  axi_wr_reqpkt_t  [NUM_REQ-1:0]     req_i,
    output axi_wr_rdypkt_t  [NUM_REQ-1:0]     rdy_o,
    output axi_wr_resppkt_t [NUM_REQ-1:0]     resp_o,
    output axi_wr_reqpkt_t                    m_req_o,
    input  axi_wr_rdypkt_t                    m_rdy_i,
    input  axi_wr_resppkt_t                   m_resp_i,
    output logic                              m_bready_o,
    output logic [clogb2(NUM_REQ)-1:0]        gnt_idx_o,
    output logic                              busy_o,
    output logic                              timeout_err_o
);

    localparam int IW = clogb2(NUM_REQ);

    wrarb_state_t   state_q, state_d;
    logic [IW-1:0]  gnt_q, gnt_d, rr_q, rr_d;
    logic           aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [NUM_REQ-1:0] pend;
    logic [IW-1:0]  pick_idx;
    logic           pick_vld;
    logic           aw_fire, w_fire, finish;
    axi_wr_reqpkt_t cur;

`ifdef HAWK_WRARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // A requester is pending as soon as either channel is valid.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) pend[i] = req_i[i].awvalid | req_i[i].wvalid;
    end

    hawk_rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .pend_i (pend),
        .ptr_i  (rr_q),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld)
    );

    // Next-state and output muxing for grant, data transfer and B routing.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        m_req_o    = '0;
        rdy_o      = '0;
        resp_o     = '0;
        m_bready_o = 1'b0;
        aw_fire    = 1'b0;
        w_fire     = 1'b0;
        finish     = 1'b0;
        cur        = req_i[gnt_q];
`ifdef HAWK_WRARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick_idx;
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                m_req_o         = cur;
                m_req_o.awvalid = cur.awvalid & ~aw_done_q;
                m_req_o.wvalid  = cur.wvalid & ~w_done_q;
                rdy_o[gnt_q].awready = m_rdy_i.awready & ~aw_done_q;
                rdy_o[gnt_q].wready  = m_rdy_i.wready & ~w_done_q;
                aw_fire   = m_req_o.awvalid & m_rdy_i.awready;
                w_fire    = m_req_o.wvalid & m_rdy_i.wready;
                aw_done_d = aw_done_q | aw_fire;
                w_done_d  = w_done_q | w_fire;
                if (aw_done_d && w_done_d) begin
                    state_d = ARB_WAIT_B;
`ifdef HAWK_WRARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ARB_WAIT_B: begin
                m_bready_o = 1'b1;
                if (m_resp_i.bvalid) begin
                    resp_o[gnt_q] = m_resp_i;
                    finish        = 1'b1;
                end
`ifdef HAWK_WRARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYC)) begin
                    resp_o[gnt_q].bresp  = AXI_RESP_SLVERR;
                    resp_o[gnt_q].bvalid = 1'b1;
                    err_d                = 1'b1;
                    finish               = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
                if (finish) begin
                    state_d   = ARB_IDLE;
                    rr_d      = (int'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State, grant, pointer and handshake-flag registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            rr_q      <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

`ifdef HAWK_WRARB_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign timeout_err_o = err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

    assign busy_o    = (state_q != ARB_IDLE);
    assign gnt_idx_o = gnt_q;

    // Elaboration sanity on the configuration.
    a_cfg: assert property (@(posedge clk_i) (NUM_REQ >= 2 && NUM_REQ <= 8 && TIMEOUT_CYC > 0));

    // A granted requester must hold a valid until it is accepted.
    a_aw_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == ARB_XFER && m_req_o.awvalid && !m_rdy_i.awready) |=> req_i[gnt_q].awvalid);
    a_w_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == ARB_XFER && m_req_o.wvalid && !m_rdy_i.wready) |=> req_i[gnt_q].wvalid);

endmodule

// File: tb/tb_hawk_axiwr_arb.sv
// Scoreboarded bench for hawk_axiwr_arb; timeout scenario built with HAWK_WRARB_TIMEOUT_EN.
module tb_hawk_axiwr_arb;
    import hacd_pkg::*;

    localparam int N = 3;
`ifdef HAWK_WRARB_TIMEOUT_EN
    localparam int BDLY = 10;
`else
    localparam int BDLY = 20;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    axi_wr_reqpkt_t  [N-1:0] req;
    axi_wr_rdypkt_t  [N-1:0] rdy;
    axi_wr_resppkt_t [N-1:0] resp;
    axi_wr_reqpkt_t  m_req;
    axi_wr_rdypkt_t  m_rdy;
    axi_wr_resppkt_t m_resp;
    logic            m_bready;
    logic [1:0]      gnt_idx;
    logic            busy, terr;

    int total = 0;
    int bad   = 0;

    typedef struct { int idx; logic [1:0] bresp; } bexp_t;
    logic [39:0] aw_q[$];
    logic [63:0] w_q[$];
    bexp_t       b_q[$];

    always #5 clk = ~clk;

    hawk_axiwr_arb #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .rdy_o(rdy), .resp_o(resp),
        .m_req_o(m_req), .m_rdy_i(m_rdy), .m_resp_i(m_resp), .m_bready_o(m_bready),
        .gnt_idx_o(gnt_idx), .busy_o(busy), .timeout_err_o(terr)
    );

    // Scoreboard: every accepted AW/W beat and every routed B is checked against the queues.
    always @(negedge clk) begin
        logic [39:0] ea;
        logic [63:0] ed;
        bexp_t       eb;
        if (!rst) begin
            if (m_req.awvalid && m_rdy.awready) begin
                total++;
                if (aw_q.size() == 0) begin bad++; $display("FAIL aw_unexpected got=%h exp=none", m_req.addr); end
                else begin
                    ea = aw_q.pop_front();
                    if (m_req.addr !== ea) begin bad++; $display("FAIL aw_addr got=%h exp=%h", m_req.addr, ea); end
                end
            end
            if (m_req.wvalid && m_rdy.wready) begin
                total++;
                if (w_q.size() == 0) begin bad++; $display("FAIL w_unexpected got=%h exp=none", m_req.data); end
                else begin
                    ed = w_q.pop_front();
                    if (m_req.data !== ed) begin bad++; $display("FAIL w_data got=%h exp=%h", m_req.data, ed); end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (resp[i].bvalid) begin
                    total++;
                    if (b_q.size() == 0) begin bad++; $display("FAIL b_unexpected got=idx%0d/%b exp=none", i, resp[i].bresp); end
                    else begin
                        eb = b_q.pop_front();
                        if (eb.idx != i || resp[i].bresp !== eb.bresp) begin
                            bad++; $display("FAIL b_route got=idx%0d/%b exp=idx%0d/%b", i, resp[i].bresp, eb.idx, eb.bresp);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input logic [39:0] a, input logic aw, input logic w);
        req[i].addr    = a;
        req[i].data    = {24'h0, a};
        req[i].strb    = 8'hff;
        req[i].awvalid = aw;
        req[i].wvalid  = w;
    endtask

    task automatic push_xfer(input logic [39:0] a);
        aw_q.push_back(a);
        w_q.push_back({24'h0, a});
    endtask

    function automatic logic [39:0] rr_addr(input int i, input int t);
        return 40'h10_0000_0000 + 40'(i * 16'h100 + t);
    endfunction

    task automatic test_reset();
        rst = 1'b1; req = '0; m_rdy = '0; m_resp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (m_req !== '0)  begin bad++; $display("FAIL rst_mreq got=%h exp=0", m_req); end
        total++; if (rdy !== '0)    begin bad++; $display("FAIL rst_rdy got=%h exp=0", rdy); end
        total++; if (resp !== '0)   begin bad++; $display("FAIL rst_resp got=%h exp=0", resp); end
        total++; if (m_bready !== 1'b0) begin bad++; $display("FAIL rst_bready got=%b exp=0", m_bready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (terr !== 1'b0) begin bad++; $display("FAIL rst_terr got=%b exp=0", terr); end
        total++; if (gnt_idx !== 2'd0) begin bad++; $display("FAIL rst_gnt got=%0d exp=0", gnt_idx); end
        tick(); rst = 1'b0;
    endtask

    task automatic test_single();
        bexp_t e;
        set_req(1, 40'hFF_F620_0040, 1'b1, 1'b1);
        push_xfer(40'hFF_F620_0040);
        tick(); m_rdy = 2'b11;
        @(negedge clk);
        total++; if (m_req.addr !== 40'hFF_F620_0040) begin bad++; $display("FAIL single_addr got=%h exp=fff6200040", m_req.addr); end
        total++; if ({m_req.awvalid, m_req.wvalid} !== 2'b11) begin bad++; $display("FAIL single_valids got=%b exp=11", {m_req.awvalid, m_req.wvalid}); end
        total++; if (rdy[1] !== 2'b11) begin bad++; $display("FAIL single_rdy1 got=%b exp=11", rdy[1]); end
        total++; if ({rdy[0], rdy[2]} !== 4'b0) begin bad++; $display("FAIL single_rdy_other got=%b exp=0000", {rdy[0], rdy[2]}); end
        total++; if (gnt_idx !== 2'd1) begin bad++; $display("FAIL single_gnt got=%0d exp=1", gnt_idx); end
        total++; if (m_bready !== 1'b0) begin bad++; $display("FAIL single_bready_xfer got=%b exp=0", m_bready); end
        tick(); req[1].awvalid = 1'b0; req[1].wvalid = 1'b0; m_rdy = 2'b00;
        e.idx = 1; e.bresp = 2'b00; b_q.push_back(e);
        m_resp = '{bresp: 2'b00, bvalid: 1'b1};
        @(negedge clk);
        total++; if (m_bready !== 1'b1) begin bad++; $display("FAIL single_bready_waitb got=%b exp=1", m_bready); end
        total++; if ({m_req.awvalid, m_req.wvalid} !== 2'b00) begin bad++; $display("FAIL single_waitb_valids got=%b exp=00", {m_req.awvalid, m_req.wvalid}); end
        tick(); m_resp = '0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b exp=0", busy); end
        total++; if (m_bready !== 1'b0) begin bad++; $display("FAIL single_bready_idle got=%b exp=0", m_bready); end
        tick();
    endtask

    task automatic test_round_robin();
        int   cnt[N];
        logic acc[N];
        bexp_t e;
        int   g;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < N; i++) begin cnt[i] = 0; acc[i] = 1'b0; set_req(i, rr_addr(i, 0), 1'b1, 1'b1); end
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < N; i++) begin
                push_xfer(rr_addr(i, t));
                e.idx = i; e.bresp = 2'b00; b_q.push_back(e);
            end
        m_rdy = 2'b11; m_resp = '{bresp: 2'b00, bvalid: 1'b1};
        for (int c = 0; c < 100 && b_q.size() > 0; c++) begin
            @(negedge clk);
            g = (b_q.size() > 0) ? b_q[0].idx : -1;
            for (int j = 0; j < N; j++) begin
                if (j != g) begin
                    total++; if (rdy[j] !== 2'b00) begin bad++; $display("FAIL rr_nongrant_rdy%0d got=%b exp=00", j, rdy[j]); end
                end
                acc[j] = rdy[j].awready && req[j].awvalid;
            end
            if (b_q.size() == 0) break;
            tick();
            for (int j = 0; j < N; j++) if (acc[j]) begin
                cnt[j]++;
                if (cnt[j] == 2) begin req[j].awvalid = 1'b0; req[j].wvalid = 1'b0; end
                else set_req(j, rr_addr(j, cnt[j]), 1'b1, 1'b1);
            end
        end
        total++; if (b_q.size() != 0) begin bad++; $display("FAIL rr_timeout got=%0d left exp=0", b_q.size()); end
        tick(); m_resp = '0; m_rdy = '0; req = '0;
    endtask

    task automatic test_split();
        bexp_t e;
        int    errs;
        set_req(0, 40'h00_1111_0000, 1'b1, 1'b1);
        push_xfer(40'h00_1111_0000);
        tick(); m_rdy = 2'b10;
        @(negedge clk);
        total++; if (m_req.awvalid !== 1'b1) begin bad++; $display("FAIL split_aw_c1 got=%b exp=1", m_req.awvalid); end
        tick(); m_rdy = 2'b00;
        @(negedge clk);
        total++; if ({m_req.awvalid, m_req.wvalid} !== 2'b01) begin bad++; $display("FAIL split_mask_c2 got=%b exp=01", {m_req.awvalid, m_req.wvalid}); end
        tick(); m_rdy = 2'b10;
        @(negedge clk);
        total++; if (rdy[0] !== 2'b00) begin bad++; $display("FAIL split_rdy_c3 got=%b exp=00", rdy[0]); end
        total++; if (m_req.awvalid !== 1'b0) begin bad++; $display("FAIL split_aw_c3 got=%b exp=0", m_req.awvalid); end
        tick(); m_rdy = 2'b01;
        @(negedge clk);
        total++; if (rdy[0] !== 2'b01) begin bad++; $display("FAIL split_rdy_c4 got=%b exp=01", rdy[0]); end
        total++; if (busy !== 1'b1 || m_bready !== 1'b0) begin bad++; $display("FAIL split_state_c4 got=%b%b exp=10", busy, m_bready); end
        tick(); m_rdy = 2'b00; req[0].awvalid = 1'b0; req[0].wvalid = 1'b0;
        @(negedge clk);
        total++; if (m_bready !== 1'b1) begin bad++; $display("FAIL split_waitb_entry got=%b exp=1", m_bready); end
        errs = 0;
        for (int k = 1; k < BDLY; k++) begin
            tick();
            @(negedge clk);
            if (resp !== '0 || m_bready !== 1'b1) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL split_waitb_hold got=%0d bad cycles exp=0", errs); end
        tick(); m_resp = '{bresp: 2'b10, bvalid: 1'b1};
        e.idx = 0; e.bresp = 2'b10; b_q.push_back(e);
        @(negedge clk);
        total++; if (resp[0] !== 3'b101) begin bad++; $display("FAIL split_bresp got=%b exp=101", resp[0]); end
        tick(); m_resp = '0;
        @(negedge clk);
        total++; if (resp !== '0 || busy !== 1'b0 || m_bready !== 1'b0) begin bad++; $display("FAIL split_after got=%h/%b/%b exp=0/0/0", resp, busy, m_bready); end
        total++; if (terr !== 1'b0) begin bad++; $display("FAIL split_terr got=%b exp=0", terr); end
        tick();
    endtask

    task automatic test_reset_mid();
        bexp_t e;
        set_req(2, 40'h22_0000_2222, 1'b1, 1'b1);
        tick(); m_rdy = 2'b00;
        @(negedge clk);
        total++; if (gnt_idx !== 2'd2) begin bad++; $display("FAIL rstmid_gnt2 got=%0d exp=2", gnt_idx); end
        total++; if (m_req.addr !== 40'h22_0000_2222) begin bad++; $display("FAIL rstmid_addr2 got=%h exp=2200002222", m_req.addr); end
        #1 rst = 1'b1; set_req(0, 40'h00_0000_0abc, 1'b1, 1'b1);
        #1;
        total++; if (m_req !== '0 || rdy !== '0 || resp !== '0) begin bad++; $display("FAIL rstmid_outs got=%h/%h/%h exp=0", m_req, rdy, resp); end
        total++; if (busy !== 1'b0 || m_bready !== 1'b0 || gnt_idx !== 2'd0) begin bad++; $display("FAIL rstmid_ctl got=%b/%b/%0d exp=0/0/0", busy, m_bready, gnt_idx); end
        tick(); rst = 1'b0;
        push_xfer(40'h00_0000_0abc);
        tick(); m_rdy = 2'b11; req[2].awvalid = 1'b0; req[2].wvalid = 1'b0;
        @(negedge clk);
        total++; if (gnt_idx !== 2'd0) begin bad++; $display("FAIL rstmid_gnt0 got=%0d exp=0", gnt_idx); end
        tick(); m_rdy = 2'b00; req[0].awvalid = 1'b0; req[0].wvalid = 1'b0;
        e.idx = 0; e.bresp = 2'b00; b_q.push_back(e);
        m_resp = '{bresp: 2'b00, bvalid: 1'b1};
        @(negedge clk);
        total++; if (m_bready !== 1'b1) begin bad++; $display("FAIL rstmid_waitb got=%b exp=1", m_bready); end
        tick(); m_resp = '0;
    endtask

`ifdef HAWK_WRARB_TIMEOUT_EN
    task automatic test_timeout();
        bexp_t e;
        int    errs;
        set_req(1, 40'h11_0000_0016, 1'b1, 1'b1);
        push_xfer(40'h11_0000_0016);
        tick(); m_rdy = 2'b11;
        tick(); m_rdy = 2'b00; req[1].awvalid = 1'b0; req[1].wvalid = 1'b0;
        errs = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (resp !== '0 || m_bready !== 1'b1) errs++;
            tick();
        end
        total++; if (errs != 0) begin bad++; $display("FAIL to_early got=%0d bad cycles exp=0", errs); end
        e.idx = 1; e.bresp = 2'b10; b_q.push_back(e);
        @(negedge clk);
        total++; if (resp[1] !== 3'b101) begin bad++; $display("FAIL to_slverr got=%b exp=101", resp[1]); end
        tick();
        @(negedge clk);
        total++; if (terr !== 1'b1) begin bad++; $display("FAIL to_terr got=%b exp=1", terr); end
        total++; if (busy !== 1'b0 || m_bready !== 1'b0) begin bad++; $display("FAIL to_idle got=%b%b exp=00", busy, m_bready); end
        tick(); m_resp = '{bresp: 2'b00, bvalid: 1'b1};
        @(negedge clk);
        total++; if (resp !== '0) begin bad++; $display("FAIL to_late_b got=%h exp=0", resp); end
        tick(); m_resp = '0;
        @(negedge clk);
        total++; if (terr !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", terr); end
        tick();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_split();
        test_reset_mid();
`ifdef HAWK_WRARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) tick();
        total++; if (aw_q.size() != 0 || w_q.size() != 0 || b_q.size() != 0) begin
            bad++; $display("FAIL sb_drain got=%0d/%0d/%0d exp=0/0/0", aw_q.size(), w_q.size(), b_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hawk_axiwr_arb.md
Name: hawk_axiwr_arb

Overview:
- Round-robin arbiter sharing the single hawk_axiwr_master write port between NUM_REQ write requesters (page-write manager, TOL/ATT updater, zspage migrator).
- Each requester issues axi_wr_reqpkt_t and receives axi_wr_rdypkt_t and axi_wr_resppkt_t.
- One transaction is in flight at a time. The grant is held from the first AW/W beat until its B response is routed back.
- Sits between the managers and hawk_axiwr_master.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYC, 1024, B-response watchdog limit in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  NUM_REQ x $bits(axi_wr_reqpkt_t)  per-requester addr/data/strb/awvalid/wvalid.
- rdy_o  out  NUM_REQ x 2  per-requester {awready,wready}.
- resp_o  out  NUM_REQ x 3  per-requester {bresp,bvalid}.
- m_req_o  out  $bits(axi_wr_reqpkt_t)  to hawk_axiwr_master.
- m_rdy_i  in  2  {awready,wready} from master.
- m_resp_i  in  3  {bresp,bvalid} from master.
- m_bready_o  out  1  B-channel ready to master.
- gnt_idx_o  out  clogb2(NUM_REQ)  current grant, for debug.
- busy_o  out  1  state != IDLE.
- timeout_err_o  out  1  sticky watchdog error.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, rr_ptr=0, gnt=0, aw_done=0, w_done=0.
  - All outputs 0: m_req_o, rdy_o, resp_o, m_bready_o, busy_o, timeout_err_o.
  - Reset mid-transaction abandons the transaction. No response is delivered.
- States:
  - IDLE:
    - A requester is pending when awvalid|wvalid.
    - Choose the first pending index searching from rr_ptr upward, with wrap modulo NUM_REQ.
    - Register it as gnt and go to XFER.
    - Grant decision takes one cycle. No master valid is driven in IDLE.
  - XFER:
    - m_req_o = req_i[gnt] with awvalid masked by !aw_done and wvalid masked by !w_done.
    - rdy_o[gnt] = m_rdy_i masked by the same flags. rdy_o of other requesters = 0.
    - aw_done sets on m awvalid&awready. w_done sets on wvalid&wready.
    - When both handshakes are complete (including both in the same cycle, or one completing while the other is already done), go to WAIT_B on the next edge.
  - WAIT_B:
    - m_bready_o=1 and m_req_o valids = 0.
    - On m_resp_i.bvalid, resp_o[gnt] = m_resp_i for that cycle (combinational pass-through). Other resp_o = 0.
    - Next state IDLE. rr_ptr = (gnt+1) mod NUM_REQ. Done flags clear.
- Fixed minimum turnaround: grant cycle + ≥1 XFER cycle + ≥1 WAIT_B cycle. A back-to-back new grant occurs in the cycle after the return to IDLE.
- Non-granted requesters see rdy=0 and must hold their valids (AXI rule).
- A granted requester deasserting a valid before its handshake is illegal. Flag with an assertion only.
- A requester presenting only awvalid or only wvalid is still eligible for the grant.
- Single requester pending continuously: it is re-granted every transaction. No starvation, since the pointer advances past the winner.
- m_resp_i.bvalid outside WAIT_B is ignored (m_bready_o=0).

Optional Feature:
- Macro: HAWK_WRARB_TIMEOUT_EN.
- Defined:
  - A counter resets on entry to WAIT_B and increments each cycle without bvalid.
  - On reaching TIMEOUT_CYC, deliver resp_o[gnt] = {bresp=2'b10 SLVERR, bvalid=1} for one cycle.
  - Then set timeout_err_o (sticky until reset) and go to IDLE.
  - A late B from the master is then dropped, since m_bready_o=0 in IDLE.
- Undefined: no counter; WAIT_B waits indefinitely; timeout_err_o tied 0.

Decomposition:
- hacd_pkg:
  - Add typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_WAIT_B} wrarb_state_t.
  - Add constant AXI_RESP_SLVERR=2'b10.
  - Reuse axi_wr_reqpkt_t, axi_wr_rdypkt_t, axi_wr_resppkt_t and clogb2 from the package.
- Sub-module hawk_rr_picker: combinational pending-vector + pointer -> index/valid. Reusable later by the read-side arbiter.

Test Plan:
- Single requester: req1 sends addr=0xFFF6200040 with both valids; m_rdy=2'b11 on the first XFER cycle.
  - Expect m_req_o.addr=0xFFF6200040 one cycle after the request.
  - Expect WAIT_B next; bresp=0 routed only to resp_o[1]; busy_o low after.
- All 3 requesters pending continuously for 6 transactions.
  - Expect grant order 0,1,2,0,1,2.
  - Non-granted rdy_o=0 throughout.
- Split handshake: awready at XFER cycle 1, wready at cycle 4.
  - Expect awvalid masked from cycle 2 on.
  - WAIT_B entered after cycle 4; exactly one AW and one W accepted.
- B returns bresp=2'b10 after 20 cycles: resp_o[gnt]={2'b10,1} for exactly one cycle; m_bready_o high only in WAIT_B.
- rst_i asserted mid-XFER for req2: all outputs 0 immediately; after release, requester 0 is granted first.
- With HAWK_WRARB_TIMEOUT_EN and TIMEOUT_CYC=16: no B.
  - Expect SLVERR to the granted requester 16 cycles after WAIT_B entry.
  - timeout_err_o=1 sticky; a later bvalid is ignored.
